// File: rtl/ks32_addsub_pipe_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone adder/subtractor.
package ks32_addsub_pipe_pkg;

  localparam int unsigned KS_WIDTH = 32;

  localparam logic KS_OP_ADD = 1'b0;
  localparam logic KS_OP_SUB = 1'b1;

  function automatic int unsigned ks_levels(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/ks_prefix_cell.sv
// Kogge-Stone black cell; used as a gray cell by leaving p_o unconnected downstream.
module ks_prefix_cell (
  input  logic g_hi_i,
  input  logic p_hi_i,
  input  logic g_lo_i,
  input  logic p_lo_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = g_hi_i | (p_hi_i & g_lo_i);
  assign p_o = p_hi_i & p_lo_i;

endmodule

// File: rtl/ks32_addsub_pipe.sv
// Three-stage Kogge-Stone add/sub with valid/ready on both sides and a bubble-collapsing
// ready chain; prefix levels are split between stages 2 and 3.
module ks32_addsub_pipe
  import ks32_addsub_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int unsigned LEVELS = ks_levels(WIDTH);
  localparam int unsigned SPLIT  = (LEVELS + 1) / 2;

  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic ld1, ld2, ld3;

  // Stage 1 state
  logic [WIDTH-1:0] g1_q, p1_q;
  logic             cin1_q, sub1_q, am1_q, bm1_q;
  // Stage 2 state
  logic [WIDTH-1:0] g2_q, pg2_q, p2_q;
  logic             cin2_q, sub2_q, am2_q, bm2_q;
  // Stage 3 state
  logic [WIDTH-1:0] s_q;
  logic             co_q, ov_q;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = (sub == KS_OP_SUB) ? ~b : b;
  assign cin_eff = (sub == KS_OP_SUB) ? ~ci : ci;

  always_comb begin
    ld3      = !v3_q || out_ready;
    ld2      = !v2_q || ld3;
    ld1      = !v1_q || ld2;
    in_ready = ld1;
    v1_d     = ld1 ? in_valid : v1_q;
    v2_d     = ld2 ? v1_q : v2_q;
    v3_d     = ld3 ? v2_q : v3_q;
  end

  // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
  logic [SPLIT:0][WIDTH-1:0] ga, pa;
  assign ga[0] = {g1_q[WIDTH-1:1], g1_q[0] | (p1_q[0] & cin1_q)};
  assign pa[0] = p1_q;

  for (genvar l = 0; l < SPLIT; l++) begin : g_lvl_a
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_cell
        ks_prefix_cell u_cell (
          .g_hi_i (ga[l][i]),
          .p_hi_i (pa[l][i]),
          .g_lo_i (ga[l][i-(1<<l)]),
          .p_lo_i (pa[l][i-(1<<l)]),
          .g_o    (ga[l+1][i]),
          .p_o    (pa[l+1][i])
        );
      end else begin : g_pass
        assign ga[l+1][i] = ga[l][i];
        assign pa[l+1][i] = pa[l][i];
      end
    end
  end

  logic [LEVELS:SPLIT][WIDTH-1:0] gb, pb;
  assign gb[SPLIT] = g2_q;
  assign pb[SPLIT] = pg2_q;

  for (genvar l = SPLIT; l < LEVELS; l++) begin : g_lvl_b
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_cell
        ks_prefix_cell u_cell (
          .g_hi_i (gb[l][i]),
          .p_hi_i (pb[l][i]),
          .g_lo_i (gb[l][i-(1<<l)]),
          .p_lo_i (pb[l][i-(1<<l)]),
          .g_o    (gb[l+1][i]),
          .p_o    (pb[l+1][i])
        );
      end else begin : g_pass
        assign gb[l+1][i] = gb[l][i];
        assign pb[l+1][i] = pb[l][i];
      end
    end
  end

  logic unused_p;
  assign unused_p = ^pb[LEVELS];

  logic [WIDTH-1:0] sum;
  logic             co_d, ov_d;
  assign sum  = p2_q ^ {gb[LEVELS][WIDTH-2:0], cin2_q};
  // Subtract reports borrow, i.e. the inverted raw carry.
  assign co_d = gb[LEVELS][WIDTH-1] ^ (sub2_q == KS_OP_SUB);
  assign ov_d = (am2_q == bm2_q) && (sum[WIDTH-1] != am2_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      cin1_q <= 1'b0;
      sub1_q <= 1'b0;
      am1_q  <= 1'b0;
      bm1_q  <= 1'b0;
      g2_q   <= '0;
      pg2_q  <= '0;
      p2_q   <= '0;
      cin2_q <= 1'b0;
      sub2_q <= 1'b0;
      am2_q  <= 1'b0;
      bm2_q  <= 1'b0;
      s_q    <= '0;
      co_q   <= 1'b0;
      ov_q   <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (ld1) begin
        g1_q   <= a & b_eff;
        p1_q   <= a ^ b_eff;
        cin1_q <= cin_eff;
        sub1_q <= sub;
        am1_q  <= a[WIDTH-1];
        bm1_q  <= b_eff[WIDTH-1];
      end
      if (ld2) begin
        g2_q   <= ga[SPLIT];
        pg2_q  <= pa[SPLIT];
        p2_q   <= p1_q;
        cin2_q <= cin1_q;
        sub2_q <= sub1_q;
        am2_q  <= am1_q;
        bm2_q  <= bm1_q;
      end
      if (ld3) begin
        s_q  <= sum;
        co_q <= co_d;
        ov_q <= ov_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign s         = s_q;
  assign co        = co_q;
  assign ov        = ov_q;

endmodule

// File: tb/tb_ks32_addsub_pipe.sv
// Randomised and directed bench for ks32_addsub_pipe against an arithmetic reference queue.
module tb_ks32_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        ci, sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        co, ov;

  int n_checks = 0;
  int n_errors = 0;
  int out_cnt  = 0;
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: never ready
  int stall_cnt = 0;
  logic saw_block = 1'b0;

  logic [33:0] q[$];
  logic        stall_prev = 1'b0;
  logic [34:0] held;
  logic [33:0] exp_r;

  ks32_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .co        (co),
    .ov        (ov)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Returns {ov, co, s} from plain unsigned/signed arithmetic.
  function automatic logic [33:0] model(input logic [31:0] xa, input logic [31:0] xb,
                                        input logic xci, input logic xsub);
    logic [32:0] u;
    longint      sa, sb, r;
    logic        o;
    sa = longint'($signed(xa));
    sb = longint'($signed(xb));
    if (!xsub) begin
      u = {1'b0, xa} + {1'b0, xb} + {32'b0, xci};
      r = sa + sb + longint'(xci);
    end else begin
      u = {1'b0, xa} - {1'b0, xb} - {32'b0, xci};
      r = sa - sb - longint'(xci);
    end
    o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    return {o, u[32], u[31:0]};
  endfunction

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check_eq("stall_hold", {29'b0, out_valid, s, co, ov}, {29'b0, held});
      check_eq("in_ready", in_ready, (q.size() < 3) || out_ready);
      if (q.size() == 0) check_eq("idle_valid", out_valid, 0);
      if (in_valid && !in_ready && q.size() == 3) saw_block = 1'b1;
      if (out_valid && out_ready && q.size() > 0) begin
        exp_r = q.pop_front();
        check_eq("result", {ov, co, s}, exp_r);
        out_cnt++;
      end
      if (in_valid && in_ready) q.push_back(model(a, b, ci, sub));
      stall_prev = out_valid && !out_ready;
      held       = {out_valid, s, co, ov};
    end
  end

  // Offer one beat and return just after the edge that accepts it.
  task automatic push_beat(input logic [31:0] xa, input logic [31:0] xb,
                           input logic xci, input logic xsub);
    int waited = 0;
    a = xa; b = xb; ci = xci; sub = xsub; in_valid = 1'b1;
    #1;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #2;
      waited++;
    end
    if (waited >= 100) check_eq("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    rdy_mode = 0;
    while (q.size() != 0 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("drain", q.size(), 0);
  endtask

  // Directed beat on an empty, always-ready pipe: checks latency and value.
  task automatic send_one(input logic [31:0] xa, input logic [31:0] xb, input logic xci,
                          input logic xsub, input logic [33:0] exp);
    int n = 1;
    push_beat(xa, xb, xci, xsub);
    while (!out_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("latency", n, 3);
    check_eq("directed", {ov, co, s}, exp);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] bp_a[9] = '{32'd5, 32'd37, 32'd125, 32'd63, 32'd122, 32'd245, 32'd3, 32'd100,
                           32'd127};
  logic [31:0] bp_b[9] = '{32'd10, 32'd48, 32'd110, 32'd211, 32'd11, 32'd2, 32'd90, 32'd200,
                           32'd127};

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_eq("reset", {28'b0, out_valid, s, co, ov, in_ready}, 64'h1);

    send_one(32'd5, 32'd10, 1'b1, 1'b0, {1'b0, 1'b0, 32'd16});
    send_one(32'd37, 32'd48, 1'b0, 1'b1, {1'b0, 1'b1, 32'hFFFF_FFF5});
    send_one(32'd127, 32'd27, 1'b1, 1'b1, {1'b0, 1'b0, 32'd99});
    send_one(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b1, 1'b0, 32'h8000_0000});
    send_one(32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, {1'b0, 1'b1, 32'h0});
    send_one(32'h8000_0000, 32'd1, 1'b0, 1'b1, {1'b1, 1'b0, 32'h7FFF_FFFF});
    send_one(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0});
    send_one(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, {1'b0, 1'b1, 32'h0});

    // Backpressure on the legacy pairs, with one long stall.
    rdy_mode = 1;
    saw_block = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) stall_cnt = 6;
      push_beat(bp_a[i], bp_b[i], (i % 2) == 0, 1'b0);
    end
    drain();
    check_eq("inready_fall", saw_block, 1);

    // Full throughput: one result per cycle after the fill.
    base = out_cnt;
    for (int i = 0; i < 1000; i++) push_beat($urandom, $urandom, 1'($urandom), 1'($urandom));
    check_eq("throughput", out_cnt - base, 997);
    drain();

    // Random mix with corner operands and random backpressure.
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) stall_cnt = 6;
      push_beat(pick(), pick(), 1'($urandom), 1'($urandom));
    end
    drain();

    // Reset with three beats in flight; a beat offered during reset is dropped.
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) push_beat($urandom, $urandom, 1'b0, 1'b0);
    rst = 1'b1; in_valid = 1'b1; a = 32'd1; b = 32'd2; ci = 1'b0; sub = 1'b0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    check_eq("mid_reset", {28'b0, out_valid, s, co, ov, in_ready}, 64'h1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("post_reset_idle", out_valid, 0);
    send_one(32'd100, 32'd200, 1'b1, 1'b0, {1'b0, 1'b0, 32'd301});
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
